// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and constants for the display scan sequencer
// Purpose: scan FSM state encoding, hex-to-7-segment table and the blank cathode code.
// Ports: none (package).
package scan_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_e;

  // Cathode pattern with every segment off ({g,f,e,d,c,b,a}, active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex digit 0..F to active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] HEX7_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7_decode.sv
// rtl/hex7_decode.sv - combinational hex nibble to 7-segment decoder
// Purpose: table lookup of one hex digit into an active-low cathode pattern.
// Ports:
//   nib_i  in  4  hex digit
//   seg_o  out 7  cathodes {g,f,e,d,c,b,a}, active-low
module hex7_decode
  import scan_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX7_LUT[nib_i];

endmodule

// File: rtl/seg_scan_sched.sv
// rtl/seg_scan_sched.sv - count tick, direction latch and 7-segment scan sequencer
// Purpose: generates a count strobe every 2^SW1 cycles with a direction sampled on the
//   strobe, and time-multiplexes an NDIG-digit common-anode display with a blank gap
//   at the start of every digit slot.
// Ports:
//   clkt       in   1      system clock
//   rstt       in   1      synchronous reset, active-high
//   SW1        in   5      rate select, tick period = 2^SW1 cycles
//   udt        in   1      direction request, 1 = up
//   digit_nib  in   4      nibble of the digit addressed by digit_sel
//   count_en   out  1      one-cycle count strobe
//   count_dir  out  1      direction applied on count_en
//   digit_sel  out  SEL_W  digit currently scanned
//   AN1        out  NDIG   anodes, active-low
//   Cnode1     out  7      cathodes {g,f,e,d,c,b,a}, active-low, registered
//   seg        out  1      decimal point, active-low (up indicator on digit 0)
module seg_scan_sched
  import scan_pkg::*;
#(
  parameter int NDIG      = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  parameter int PRE_W     = 32,
  localparam int SEL_W    = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic             clkt,
  input  logic             rstt,
  input  logic [4:0]       SW1,
  input  logic             udt,
  input  logic [3:0]       digit_nib,
  output logic             count_en,
  output logic             count_dir,
  output logic [SEL_W-1:0] digit_sel,
  output logic [NDIG-1:0]  AN1,
  output logic [6:0]       Cnode1,
  output logic             seg
);

  localparam int TMR_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(SCAN_DIV - 1);
  localparam logic [TMR_W-1:0] BLANK_LAST = TMR_W'(BLANK_CYC - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NDIG - 1);

  // ---------------- rate tick and direction ----------------
  logic [4:0]       sw_q, sw_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] pre_mask;
  logic             en_q, en_d;
  logic             dir_q, dir_d;
  logic             sw_chg;

  assign pre_mask = (PRE_W'(1) << sw_q) - PRE_W'(1);
  assign sw_chg   = (SW1 != sw_q);

  // A rate change restarts the period and suppresses any tick due on the same edge.
  always_comb begin
    sw_d  = SW1;
    pre_d = pre_q + PRE_W'(1);
    en_d  = 1'b0;
    if (sw_chg) begin
      pre_d = '0;
    end else if (pre_q == pre_mask) begin
      pre_d = '0;
      en_d  = 1'b1;
    end
  end

  // Direction is only sampled on the edge that ends a strobe cycle.
  assign dir_d = en_q ? udt : dir_q;

  // ---------------- scan FSM ----------------
  scan_state_e      state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TMR_W'(1);
    sel_d   = sel_q;
    case (state_q)
      S_BLANK: begin
        if (tmr_q == BLANK_LAST) begin
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (tmr_q == TMR_LAST) begin
          state_d = S_BLANK;
          tmr_d   = '0;
          sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
        end
      end
      default: begin
        state_d = S_BLANK;
        tmr_d   = '0;
      end
    endcase
  end

  // ---------------- cathodes ----------------
  logic [6:0] dec_seg;
  logic [6:0] cnode_q, cnode_d;

  hex7_decode u_hex7_decode (
    .nib_i (digit_nib),
    .seg_o (dec_seg)
  );

  // Loaded against the next state so the blank code lines up with the registered state.
  assign cnode_d = (state_d == S_DRIVE) ? dec_seg : SEG_BLANK;

  // ---------------- registers ----------------
  always_ff @(posedge clkt) begin
    if (rstt) begin
      // Taking SW1 directly means the first tick after release follows 2^SW1 cycles later.
      sw_q    <= SW1;
      pre_q   <= '0;
      en_q    <= 1'b0;
      dir_q   <= 1'b1;
      state_q <= S_BLANK;
      tmr_q   <= '0;
      sel_q   <= '0;
      cnode_q <= SEG_BLANK;
    end else begin
      sw_q    <= sw_d;
      pre_q   <= pre_d;
      en_q    <= en_d;
      dir_q   <= dir_d;
      state_q <= state_d;
      tmr_q   <= tmr_d;
      sel_q   <= sel_d;
      cnode_q <= cnode_d;
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    AN1 = '1;
    if (state_q == S_DRIVE) begin
      AN1 = ~(NDIG'(1) << sel_q);
    end
  end

  assign count_en  = en_q;
  assign count_dir = dir_q;
  assign digit_sel = sel_q;
  assign Cnode1    = cnode_q;
  assign seg       = ~((state_q == S_DRIVE) && (sel_q == '0) && dir_q);

endmodule

// File: tb/tb_seg_scan_sched.sv
// tb/tb_seg_scan_sched.sv - directed self-checking bench for seg_scan_sched
module tb_seg_scan_sched;

  logic       clkt;
  logic       rstt;
  logic [4:0] SW1;
  logic       udt;
  logic [3:0] digit_nib;
  logic       count_en;
  logic       count_dir;
  logic [2:0] digit_sel;
  logic [7:0] AN1;
  logic [6:0] Cnode1;
  logic       seg;

  int checks = 0;
  int errors = 0;

  seg_scan_sched #(
    .NDIG      (8),
    .SCAN_DIV  (8),
    .BLANK_CYC (2),
    .PRE_W     (32)
  ) dut (
    .clkt      (clkt),
    .rstt      (rstt),
    .SW1       (SW1),
    .udt       (udt),
    .digit_nib (digit_nib),
    .count_en  (count_en),
    .count_dir (count_dir),
    .digit_sel (digit_sel),
    .AN1       (AN1),
    .Cnode1    (Cnode1),
    .seg       (seg)
  );

  initial clkt = 1'b0;
  always #5 clkt = ~clkt;

  // Datapath stand-in: digit memory muxed by digit_sel.
  function automatic logic [3:0] nib_of(input logic [2:0] s);
    case (s)
      3'd0: nib_of = 4'h0;
      3'd1: nib_of = 4'h1;
      3'd2: nib_of = 4'hF;
      3'd3: nib_of = 4'h3;
      3'd4: nib_of = 4'hA;
      3'd5: nib_of = 4'h5;
      3'd6: nib_of = 4'hB;
      default: nib_of = 4'h8;
    endcase
  endfunction

  // Hand-decoded cathodes for the nibbles above.
  function automatic logic [6:0] exp_cathode(input int s);
    case (s)
      0: exp_cathode = 7'h40;
      1: exp_cathode = 7'h79;
      2: exp_cathode = 7'h0E;
      3: exp_cathode = 7'h30;
      4: exp_cathode = 7'h08;
      5: exp_cathode = 7'h12;
      6: exp_cathode = 7'h03;
      default: exp_cathode = 7'h00;
    endcase
  endfunction

  assign digit_nib = nib_of(digit_sel);

  // Holds reset for two edges and releases it on the negedge after the last reset edge.
  task automatic apply_reset(input logic [4:0] sw, input logic ud);
    @(negedge clkt);
    rstt = 1'b1;
    SW1  = sw;
    udt  = ud;
    @(negedge clkt);
    @(negedge clkt);
    rstt = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clkt);
    rstt = 1'b1;
    SW1  = 5'd0;
    udt  = 1'b1;
    @(negedge clkt);
    @(negedge clkt);
    checks += 6;
    if (AN1 !== 8'hFF) begin errors++; $display("FAIL reset_an1 got %h want ff", AN1); end
    if (Cnode1 !== 7'h7F) begin errors++; $display("FAIL reset_cnode got %h want 7f", Cnode1); end
    if (seg !== 1'b1) begin errors++; $display("FAIL reset_seg got %b want 1", seg); end
    if (count_en !== 1'b0) begin errors++; $display("FAIL reset_count_en got %b want 0", count_en); end
    if (count_dir !== 1'b1) begin errors++; $display("FAIL reset_count_dir got %b want 1", count_dir); end
    if (digit_sel !== 3'd0) begin errors++; $display("FAIL reset_digit_sel got %0d want 0", digit_sel); end
    rstt = 1'b0;
  endtask

  task automatic test_rate;
    logic exp;
    apply_reset(5'd0, 1'b1);
    for (int c = 0; c <= 8; c++) begin
      exp = (c >= 1);
      checks++;
      if (count_en !== exp) begin
        errors++; $display("FAIL rate_sw0 c=%0d got %b want %b", c, count_en, exp);
      end
      if (c < 8) @(negedge clkt);
    end
    SW1 = 5'd3;
    for (int k = 0; k < 28; k++) begin
      @(negedge clkt);
      exp = (k > 0) && (k % 8 == 0);
      checks++;
      if (count_en !== exp) begin
        errors++; $display("FAIL rate_sw3 k=%0d got %b want %b", k, count_en, exp);
      end
    end
    SW1 = 5'd4;
    for (int j = 0; j <= 32; j++) begin
      @(negedge clkt);
      exp = (j > 0) && (j % 16 == 0);
      checks++;
      if (count_en !== exp) begin
        errors++; $display("FAIL rate_sw4 j=%0d got %b want %b", j, count_en, exp);
      end
    end
  endtask

  task automatic test_scan_decode;
    int t, slot;
    logic [7:0] exp_an;
    logic [6:0] exp_cn;
    logic       exp_dp;
    apply_reset(5'd0, 1'b1);
    for (int c = 0; c < 72; c++) begin
      t      = c % 8;
      slot   = (c / 8) % 8;
      exp_an = (t < 2) ? 8'hFF : ~(8'h01 << slot);
      exp_cn = (t < 2) ? 7'h7F : exp_cathode(slot);
      exp_dp = !((t >= 2) && (slot == 0));
      checks += 4;
      if (AN1 !== exp_an) begin
        errors++; $display("FAIL scan_an1 c=%0d got %h want %h", c, AN1, exp_an);
      end
      if (digit_sel !== 3'(slot)) begin
        errors++; $display("FAIL scan_digit_sel c=%0d got %0d want %0d", c, digit_sel, slot);
      end
      if (Cnode1 !== exp_cn) begin
        errors++; $display("FAIL decode_cnode c=%0d got %h want %h", c, Cnode1, exp_cn);
      end
      if (seg !== exp_dp) begin
        errors++; $display("FAIL scan_dp c=%0d got %b want %b", c, seg, exp_dp);
      end
      @(negedge clkt);
    end
  endtask

  task automatic test_direction;
    int t, slot;
    logic exp_en, exp_dir, exp_dp;
    apply_reset(5'd3, 1'b1);
    for (int c = 0; c < 72; c++) begin
      t       = c % 8;
      slot    = (c / 8) % 8;
      exp_en  = (c > 0) && (c % 8 == 0);
      exp_dir = (c <= 16);
      exp_dp  = !((t >= 2) && (slot == 0) && exp_dir);
      checks += 3;
      if (count_en !== exp_en) begin
        errors++; $display("FAIL dir_count_en c=%0d got %b want %b", c, count_en, exp_en);
      end
      if (count_dir !== exp_dir) begin
        errors++; $display("FAIL dir_count_dir c=%0d got %b want %b", c, count_dir, exp_dir);
      end
      if (seg !== exp_dp) begin
        errors++; $display("FAIL dir_dp c=%0d got %b want %b", c, seg, exp_dp);
      end
      if (c == 10) udt = 1'b0;
      @(negedge clkt);
    end
  endtask

  task automatic test_reset_mid_drive;
    apply_reset(5'd0, 1'b1);
    for (int c = 0; c < 44; c++) @(negedge clkt);
    checks += 3;
    if (digit_sel !== 3'd5) begin errors++; $display("FAIL mid_pre_sel got %0d want 5", digit_sel); end
    if (AN1 !== 8'hDF) begin errors++; $display("FAIL mid_pre_an1 got %h want df", AN1); end
    if (count_en !== 1'b1) begin errors++; $display("FAIL mid_pre_en got %b want 1", count_en); end
    rstt = 1'b1;
    @(negedge clkt);
    checks += 5;
    if (AN1 !== 8'hFF) begin errors++; $display("FAIL mid_an1 got %h want ff", AN1); end
    if (digit_sel !== 3'd0) begin errors++; $display("FAIL mid_sel got %0d want 0", digit_sel); end
    if (count_en !== 1'b0) begin errors++; $display("FAIL mid_en got %b want 0", count_en); end
    if (Cnode1 !== 7'h7F) begin errors++; $display("FAIL mid_cnode got %h want 7f", Cnode1); end
    if (seg !== 1'b1) begin errors++; $display("FAIL mid_seg got %b want 1", seg); end
    rstt = 1'b0;
    @(negedge clkt);
    checks++;
    if (count_en !== 1'b1) begin errors++; $display("FAIL mid_first_tick got %b want 1", count_en); end
    @(negedge clkt);
    checks += 2;
    if (AN1 !== 8'hFE) begin errors++; $display("FAIL mid_restart_an1 got %h want fe", AN1); end
    if (Cnode1 !== 7'h40) begin errors++; $display("FAIL mid_restart_cnode got %h want 40", Cnode1); end
  endtask

  initial begin
    rstt = 1'b1;
    SW1  = 5'd0;
    udt  = 1'b1;
    test_reset();
    test_rate();
    test_scan_decode();
    test_direction();
    test_reset_mid_drive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
